dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Round-robin arbiter and sequencer that shares the single-port 256x8 data memory between two requesters. Port 0 is the pipeline MEM stage and port 1 is the loader/debug port. Each accepted request becomes a one-cycle registered memory access, and read data is returned one cycle later. The block sits between the requesters and the data memory's writeEn/address/writeData/readData pins. It guarantees at most one access per cycle and starvation-free service.

## Interface
- AW, 8, address width (memory depth 2^AW)
- DW, 8, data width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  access request from port 0 / 1
- we0 / we1  in  1  1 = write, 0 = read; valid while req is high
- addr0 / addr1  in  AW  access address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  one-cycle pulse: the request was accepted, payload may change
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata holds read result for that port
- rdata  out  DW  read data, shared by both ports, qualified by rvalid0/rvalid1
- mem_we  out  1  to memory writeEn
- mem_addr  out  AW  to memory address
- mem_wdata  out  DW  to memory writeData
- mem_rdata  in  DW  from memory readData (combinational read)

## Operation
- **Eligibility.** elig0 = req0 & ~gnt0 and elig1 = req1 & ~gnt1. A port whose gnt is high in the current cycle is masked, so a held req is never double-accepted. A port may therefore win at most every other cycle.
- **Arbitration.**
  - Pointer `last` holds the id of the last winner; reset value is 1, so port 0 wins the first tie.
  - Only one port eligible: that port wins.
  - Both eligible: the port != last wins.
  - No port eligible: no access, and `last` is unchanged.
- **Accept.** On a win, the following are registered at the clock edge:
  - acc_v <= 1
  - acc_id, acc_we, acc_addr, acc_wdata <= the winner's fields
  - last <= winner
  - gnt<winner> <= 1
- **Idle.** With no winner: acc_v <= 0, and both gnt <= 0.
- **Memory drive.**
  - mem_we = acc_v & acc_we.
  - mem_addr = acc_addr and mem_wdata = acc_wdata, driven from registers. Both hold their last value when idle.
  - Write data commits to memory at the end of the access cycle.
- **Read return.** If acc_v & ~acc_we, then at the end of the access cycle:
  - rdata <= mem_rdata
  - rvalid<acc_id> <= 1
  - Otherwise both rvalid <= 0, and rdata holds its value.
- **Writes.** Writes produce a gnt but no rvalid.
- **Width rules.** Addresses index 0..2^AW-1 with no wrap or overflow logic. The arbiter does not modify data.
- **Reset.** The asynchronous reset clears all registers:
  - gnt0, gnt1, rvalid0, rvalid1, mem_we: 0
  - mem_addr, mem_wdata, rdata: 0
  - acc_v: 0
  - last: 1
- **Reset mid-operation.** An in-flight access is dropped: mem_we falls immediately, so no partial write occurs, and no rvalid follows. Requesters must re-issue after reset.

## Timing
- Cycle N: req sampled at the edge ending N.
- Cycle N+1: gnt high, memory access driven, write committed at the edge ending N+1.
- Cycle N+2: rvalid high with rdata for a read.
- Latency:
  - req to gnt: 1 cycle.
  - req to rvalid: 2 cycles.
  - Throughput: 1 access per cycle with both ports active; 1 per 2 cycles from a single port.
- Requester rule: hold req/we/addr/wdata stable until gnt is seen. req still high in the gnt cycle is ignored (masked). req high in the cycle after gnt is a new request.
- Read-after-write across ports: a write in access cycle K is visible to a read accessed in K+1.
- Simultaneous rvalid on both ports is impossible; rvalid0 & rvalid1 = 0 always.
- Fairness: while both ports hold req, grants strictly alternate. A waiting port is granted within 2 cycles of req.

## Test plan
- **Reset values.** Assert rst mid-cycle with req0=1 pending → all outputs 0 asynchronously. After release, req0 read 8'd103 (memory preloaded 0x03) → gnt0 at N+1, rvalid0=1 with rdata=0x03 at N+2.
- **Tie and alternation.** req0 and req1 both held from cycle 0 (reads of 100 and 105) → gnt order 0,1,0,1. rdata returns 0x01 and 0x05 in alternation. gnt0 and gnt1 are never high together.
- **Cross-port write then read.** Port 0 writes 0xA5 to 200; port 1 reads 200 one cycle later → mem_we=1 only in port 0's access cycle, and rvalid1 carries rdata=0xA5.
- **Single-port streaming.** req0 held continuously for reads 110..113 with the address advanced on each gnt0 → gnt0 every other cycle, rdata 0x0A,0x0B,0x0C,0x0D. No duplicate accesses.
- **Reset during write.** Port 1 write of 0x77 to 150 with rst asserted in its access cycle → mem_we drops immediately, no rvalid, and mem[150] is unchanged.
- **Starvation check.** Randomized req0/req1 for 10k cycles with an assertion monitor → every request is granted within 2 cycles and exactly one rvalid per read. Final memory matches the reference model.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the
// single-port data memory. The slave view belongs to the arbiter. The master
// view belongs to the surrounding environment: the requesters plus the memory
// macro that supplies mem_rdata.
interface dmem_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          req0;
   logic          req1;
   logic          we0;
   logic          we1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          gnt0;
   logic          gnt1;
   logic          rvalid0;
   logic          rvalid1;
   logic [DW-1:0] rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the shared 256x8 data memory.
// Port 0 is the pipeline MEM stage and port 1 is the loader/debug port.
// Each winning request becomes a one-cycle registered memory access.
// Read data comes back one cycle after the access.
module dmem_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);

   logic          last;
   logic          elig0;
   logic          elig1;
   logic          win0;
   logic          win1;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   logic          gnt0_p1;
   logic          gnt1_p1;
   logic          vld_p1;
   logic          acc_id_p1;
   logic          acc_we_p1;
   logic [AW-1:0] acc_addr_p1;
   logic [DW-1:0] acc_wdata_p1;

   logic          rvld0_p2;
   logic          rvld1_p2;
   logic [DW-1:0] rdata_p2;

   // A port granted this cycle is masked so a held req is not accepted twice;
   // on a tie the port that did not win last time takes the slot.
   always_comb begin
      elig0     = bus.req0 & ~gnt0_p1;
      elig1     = bus.req1 & ~gnt1_p1;
      win0      = elig0 & (~elig1 | last);
      win1      = elig1 & (~elig0 | ~last);
      sel_we    = win1 ? bus.we1    : bus.we0;
      sel_addr  = win1 ? bus.addr1  : bus.addr0;
      sel_wdata = win1 ? bus.wdata1 : bus.wdata0;
   end

   // ---- stage p1: accept the winner and register the memory access ----
   // Address and write data are held while idle so the memory pins stay quiet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt0_p1      <= 1'b0;
         gnt1_p1      <= 1'b0;
         vld_p1       <= 1'b0;
         acc_id_p1    <= 1'b0;
         acc_we_p1    <= 1'b0;
         acc_addr_p1  <= '0;
         acc_wdata_p1 <= '0;
         last         <= 1'b1;
      end else begin
         gnt0_p1 <= win0;
         gnt1_p1 <= win1;
         vld_p1  <= win0 | win1;
         if (win0 | win1) begin
            acc_id_p1    <= win1;
            acc_we_p1    <= sel_we;
            acc_addr_p1  <= sel_addr;
            acc_wdata_p1 <= sel_wdata;
            last         <= win1;
         end
      end
   end

   // ---- stage p2: capture the read result for the port that issued it ----
   // rdata keeps its last value between reads; rvalid marks the owner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvld0_p2 <= 1'b0;
         rvld1_p2 <= 1'b0;
         rdata_p2 <= '0;
      end else if (vld_p1 & ~acc_we_p1) begin
         rvld0_p2 <= ~acc_id_p1;
         rvld1_p2 <= acc_id_p1;
         rdata_p2 <= bus.mem_rdata;
      end else begin
         rvld0_p2 <= 1'b0;
         rvld1_p2 <= 1'b0;
      end
   end

   // The write enable is gated by the access valid, which the asynchronous
   // reset clears, so a reset inside a write cycle drops the write at once.
   assign bus.mem_we    = vld_p1 & acc_we_p1;
   assign bus.mem_addr  = acc_addr_p1;
   assign bus.mem_wdata = acc_wdata_p1;
   assign bus.gnt0      = gnt0_p1;
   assign bus.gnt1      = gnt1_p1;
   assign bus.rvalid0   = rvld0_p2;
   assign bus.rvalid1   = rvld1_p2;
   assign bus.rdata     = rdata_p2;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter with a behavioral 256x8
// data memory (combinational read, write at the clock edge) and a reference
// memory that tracks the accesses in grant order.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   ntests = 0;
   int   nfail  = 0;

   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];
   bit         mem_init = 1'b0;

   dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

   dmem_arbiter #(.AW(8), .DW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input int i);
      logic [7:0] v;
      v = 8'(i - 100);
      if (i == 100) v = 8'h01;
      return v;
   endfunction

   // data memory: preload on the first edge, then write on mem_we
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
         mem_init <= 1'b1;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   assign bus.mem_rdata = mem[bus.mem_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_gnt0"},   bus.gnt0,      0);
      chk({tag, "_gnt1"},   bus.gnt1,      0);
      chk({tag, "_rv0"},    bus.rvalid0,   0);
      chk({tag, "_rv1"},    bus.rvalid1,   0);
      chk({tag, "_we"},     bus.mem_we,    0);
      chk({tag, "_addr"},   bus.mem_addr,  0);
      chk({tag, "_wdata"},  bus.mem_wdata, 0);
      chk({tag, "_rdata"},  bus.rdata,     0);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      #3 rst = 1'b0;
   endtask

   initial begin
      bit         pend0, pend1, erv0, erv1, g0, g1;
      int         w0, w1, diffs;
      logic [7:0] ed0, ed1;

      rst = 1'b1;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd103; bus.wdata0 = 8'h00;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 8'd0;   bus.wdata1 = 8'h00;

      // reset held with a pending request: everything stays at zero
      tick(); tick(); tick();
      chk_zero("rst_hold");

      // release mid-cycle; read of 103 returns preload 0x03
      #3 rst = 1'b0;
      tick();
      chk("rd103_gnt0", bus.gnt0, 1);
      chk("rd103_addr", bus.mem_addr, 8'd103);
      chk("rd103_we",   bus.mem_we, 0);
      bus.req0 = 1'b0;
      tick();
      chk("rd103_rv0",  bus.rvalid0, 1);
      chk("rd103_rdat", bus.rdata, 8'h03);
      chk("rd103_g0lo", bus.gnt0, 0);

      // reset asserted mid-cycle during an access clears outputs at once
      bus.req0 = 1'b1;
      tick();
      chk("mid_gnt0", bus.gnt0, 1);
      #2 rst = 1'b1;
      bus.req0 = 1'b0;
      #1 chk_zero("mid_rst");
      tick();
      #3 rst = 1'b0;
      tick();
      chk("mid_norv0", bus.rvalid0, 0);

      // tie and alternation: 100 on port 0, 105 on port 1, both held
      pulse_reset();
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd100;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'd105;
      tick();
      chk("tie_c1_g0", bus.gnt0, 1);
      chk("tie_c1_g1", bus.gnt1, 0);
      tick();
      chk("tie_c2_g0", bus.gnt0, 0);
      chk("tie_c2_g1", bus.gnt1, 1);
      chk("tie_c2_rv0", bus.rvalid0, 1);
      chk("tie_c2_rd", bus.rdata, 8'h01);
      tick();
      chk("tie_c3_g0", bus.gnt0, 1);
      chk("tie_c3_g1", bus.gnt1, 0);
      chk("tie_c3_rv1", bus.rvalid1, 1);
      chk("tie_c3_rv0", bus.rvalid0, 0);
      chk("tie_c3_rd", bus.rdata, 8'h05);
      bus.req0 = 1'b0;
      tick();
      chk("tie_c4_g0", bus.gnt0, 0);
      chk("tie_c4_g1", bus.gnt1, 1);
      chk("tie_c4_rv0", bus.rvalid0, 1);
      chk("tie_c4_rd", bus.rdata, 8'h01);
      bus.req1 = 1'b0;
      tick();
      chk("tie_c5_g1", bus.gnt1, 0);
      chk("tie_c5_rv1", bus.rvalid1, 1);
      chk("tie_c5_rd", bus.rdata, 8'h05);
      tick();
      chk("tie_c6_rv1", bus.rvalid1, 0);

      // port 0 writes 0xA5 to 200, port 1 reads 200 one cycle later
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'd200; bus.wdata0 = 8'hA5;
      tick();
      chk("xp_c1_g0", bus.gnt0, 1);
      chk("xp_c1_we", bus.mem_we, 1);
      chk("xp_c1_addr", bus.mem_addr, 8'd200);
      chk("xp_c1_wd", bus.mem_wdata, 8'hA5);
      bus.req0 = 1'b0;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'd200;
      tick();
      chk("xp_c2_g1", bus.gnt1, 1);
      chk("xp_c2_we", bus.mem_we, 0);
      chk("xp_c2_rv0", bus.rvalid0, 0);
      bus.req1 = 1'b0;
      tick();
      chk("xp_c3_rv1", bus.rvalid1, 1);
      chk("xp_c3_rv0", bus.rvalid0, 0);
      chk("xp_c3_rd", bus.rdata, 8'hA5);

      // single-port streaming reads 110..113, address advanced on each gnt0
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd110;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("str_gnt", bus.gnt0, 1);
         chk("str_addr", bus.mem_addr, 8'(110 + k));
         if (k < 3) bus.addr0 = 8'(111 + k);
         else       bus.req0  = 1'b0;
         tick();
         chk("str_gap", bus.gnt0, 0);
         chk("str_rv0", bus.rvalid0, 1);
         chk("str_rd", bus.rdata, 8'(10 + k));
      end

      // port 1 write of 0x77 to 150 killed by reset in its access cycle
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'd150; bus.wdata1 = 8'h77;
      tick();
      chk("rw_gnt1", bus.gnt1, 1);
      chk("rw_we", bus.mem_we, 1);
      bus.req1 = 1'b0;
      #2 rst = 1'b1;
      #1 chk("rw_we_drop", bus.mem_we, 0);
      chk("rw_gnt_drop", bus.gnt1, 0);
      tick();
      #3 rst = 1'b0;
      tick();
      chk("rw_norv1", bus.rvalid1, 0);
      chk("rw_mem150", mem[150], 8'h32);

      // randomized traffic against a reference memory in grant order
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
      pend0 = 0; pend1 = 0; erv0 = 0; erv1 = 0; w0 = 0; w1 = 0;
      ed0 = 8'h00; ed1 = 8'h00;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         tick();
         chk("rnd_rv0", bus.rvalid0, erv0);
         if (erv0) chk("rnd_rd0", bus.rdata, ed0);
         chk("rnd_rv1", bus.rvalid1, erv1);
         if (erv1) chk("rnd_rd1", bus.rdata, ed1);
         erv0 = 0; erv1 = 0; g0 = 0; g1 = 0;
         if (pend0) begin
            w0++;
            if (bus.gnt0) begin
               g0 = 1; pend0 = 0;
               if (bus.we0) ref_mem[bus.addr0] = bus.wdata0;
               else begin erv0 = 1; ed0 = ref_mem[bus.addr0]; end
            end else if (w0 >= 2) chk("rnd_late0", bus.gnt0, 1);
         end else chk("rnd_spur0", bus.gnt0, 0);
         if (pend1) begin
            w1++;
            if (bus.gnt1) begin
               g1 = 1; pend1 = 0;
               if (bus.we1) ref_mem[bus.addr1] = bus.wdata1;
               else begin erv1 = 1; ed1 = ref_mem[bus.addr1]; end
            end else if (w1 >= 2) chk("rnd_late1", bus.gnt1, 1);
         end else chk("rnd_spur1", bus.gnt1, 0);
         if (!pend0 && !g0 && $urandom_range(0, 2) != 0) begin
            pend0 = 1; w0 = 0;
            bus.we0 = 1'($urandom_range(0, 1));
            bus.addr0 = 8'($urandom_range(100, 107));
            bus.wdata0 = 8'($urandom);
         end
         if (!pend1 && !g1 && $urandom_range(0, 2) != 0) begin
            pend1 = 1; w1 = 0;
            bus.we1 = 1'($urandom_range(0, 1));
            bus.addr1 = 8'($urandom_range(100, 107));
            bus.wdata1 = 8'($urandom);
         end
         bus.req0 = pend0;
         bus.req1 = pend1;
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      tick();
      tick();
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
      chk("rnd_final_mem", diffs, 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
